fuzz_stim_sequencer: RTL

//  Sequences stimulus into the fuzzed DUT (top). It replays a loaded vector table onto the

---
 rtl/fuzz_pkg.sv | 35 +++
 rtl/fuzz_vec_mem.sv | 28 ++
 rtl/fuzz_stim_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fuzz_pkg.sv
// rtl/fuzz_pkg.sv - shared widths, FSM encoding and signature helpers for the stimulus sequencer
package fuzz_pkg;

   localparam int VEC_W = 83;
   localparam int OUT_W = 245;
   localparam int SIG_W = 32;
   localparam logic [SIG_W-1:0] SEED = 32'hFFFF_FFFF;
   localparam logic [SIG_W-1:0] POLY = 32'h04C1_1DB7;
   localparam int NSLICE = (OUT_W + SIG_W - 1) / SIG_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_BUBBLE,
      ST_DRAIN
   } fsm_state_t;

   // XOR of all SIG_W-wide slices of y; the top slice is zero-padded.
   function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] y);
      logic [NSLICE*SIG_W-1:0] pad;
      logic [SIG_W-1:0]        acc;
      pad = (NSLICE*SIG_W)'(y);
      acc = '0;
      for (int i = 0; i < NSLICE; i++) begin
         acc = acc ^ pad[i*SIG_W +: SIG_W];
      end
      return acc;
   endfunction

   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                  input logic [SIG_W-1:0] din);
      return {sig[SIG_W-2:0], ^(sig & POLY)} ^ din;
   endfunction

endpackage

// File: rtl/fuzz_vec_mem.sv
// rtl/fuzz_vec_mem.sv - vector table: flop array with synchronous write and asynchronous read
module fuzz_vec_mem
   import fuzz_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int W      = VEC_W + 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [W-1:0]      wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [W-1:0]      rdata
);

   // Contents are deliberately not reset; the table is reloaded by software.
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fuzz_stim_sequencer.sv
// rtl/fuzz_stim_sequencer.sv - replays the vector table onto the DUT bus and signs DUT outputs
module fuzz_stim_sequencer
   import fuzz_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [VEC_W-1:0]  cfg_vec,
   input  logic              cfg_bub,
   input  logic [ADDR_W:0]   num_vecs,
   input  logic              start,
   input  logic              abort,
   output logic [VEC_W-1:0]  stim,
   input  logic [OUT_W-1:0]  dut_y,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   vec_idx,
   output logic [SIG_W-1:0]  signature
);

   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(DEPTH);

   fsm_state_t state, state_n;

   logic [ADDR_W:0] num_lat;
   logic [LAT:0]    tag, tag_n, tag_rest;
   logic [VEC_W:0]  rd_entry;
   logic [VEC_W-1:0] rd_vec;
   logic            rd_bub;
   logic            last_apply, remain, drain_empty;
   logic            mem_we, run_go, run_empty, drive_apply, drive_bubble, finish, capture;

   fuzz_vec_mem #(
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W),
      .W     (VEC_W + 1)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .waddr(cfg_addr),
      .wdata({cfg_bub, cfg_vec}),
      .raddr(vec_idx[ADDR_W-1:0]),
      .rdata(rd_entry)
   );

   assign rd_vec = rd_entry[VEC_W-1:0];
   assign rd_bub = rd_entry[VEC_W];

   assign last_apply  = (vec_idx + ONE) == num_lat;
   assign remain      = vec_idx < num_lat;
   assign drain_empty = (tag_rest == '0);

   // tag[k] marks a driven stim cycle k+1 edges ago; tag[LAT] is the one whose dut_y is due now.
   always_comb begin
      tag_rest      = tag;
      tag_rest[LAT] = 1'b0;
      tag_n         = tag << 1;
      tag_n[0]      = drive_apply | drive_bubble;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      if (abort) begin
         state_n = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && (num_vecs != '0)) state_n = ST_APPLY;
            end
            ST_APPLY: begin
               if (rd_bub)          state_n = ST_BUBBLE;
               else if (last_apply) state_n = ST_DRAIN;
            end
            ST_BUBBLE: begin
               state_n = remain ? ST_APPLY : ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drain_empty) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy         = 1'b0;
      mem_we       = 1'b0;
      run_go       = 1'b0;
      run_empty    = 1'b0;
      drive_apply  = 1'b0;
      drive_bubble = 1'b0;
      finish       = 1'b0;
      capture      = tag[LAT] & ~abort;
      case (state)
         ST_IDLE: begin
            mem_we    = cfg_we;
            run_go    = start & ~abort & (num_vecs != '0);
            run_empty = start & ~abort & (num_vecs == '0);
         end
         ST_APPLY: begin
            busy        = 1'b1;
            drive_apply = ~abort;
         end
         ST_BUBBLE: begin
            busy         = 1'b1;
            drive_bubble = ~abort;
         end
         ST_DRAIN: begin
            busy   = 1'b1;
            finish = ~abort & drain_empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim      <= '0;
         done      <= 1'b0;
         vec_idx   <= '0;
         signature <= SEED;
         tag       <= '0;
         num_lat   <= '0;
      end else begin
         done <= run_empty | finish;
         if (abort) begin
            stim <= '0;
            tag  <= '0;
         end else begin
            stim <= drive_apply ? rd_vec : '0;
            tag  <= tag_n;
         end
         // Clamp oversized requests so the table address never wraps.
         if (run_go) begin
            vec_idx <= '0;
            num_lat <= (num_vecs > MAX_N) ? MAX_N : num_vecs;
         end else if (drive_apply) begin
            vec_idx <= vec_idx + ONE;
         end
         if (run_go || run_empty) begin
            signature <= SEED;
         end else if (capture) begin
            signature <= misr_step(signature, fold(dut_y));
         end
      end
   end

endmodule
